// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, blank pattern, bit order, decode result type.
package seg7_pkg;

    // Segment bus bit order: bit SEG_A is segment a, bit SEG_G is segment g.
    localparam int unsigned SEG_A       = 0;
    localparam int unsigned SEG_G       = 6;
    localparam int unsigned SEG_W       = SEG_G - SEG_A + 1;
    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned GLYPH_COUNT = 16;

    // Active-low patterns, written g..a; identical table to the hex-to-segment driver.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_GLYPH [GLYPH_COUNT] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic                legal;   // glyph or blank
        logic                blank;   // all segments off
        logic [NIBBLE_W-1:0] nibble;  // decoded value, 0 when blank or illegal
    } seg7_decode_t;

    // Forward mapping, kept beside the table so both directions share one source.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] value);
        return SEG_GLYPH[value];
    endfunction

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational inverse lookup: active-low segment pattern -> {legal, blank, nibble}.
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output seg7_decode_t     result
);

    // Match against the blank pattern first, then every glyph in the table.
    always_comb begin
        result = '0;
        if (pattern == SEG_BLANK) begin
            result.legal = 1'b1;
            result.blank = 1'b1;
        end else begin
            for (int i = 0; i < int'(GLYPH_COUNT); i++) begin
                if (pattern == SEG_GLYPH[i]) begin
                    result.legal  = 1'b1;
                    result.nibble = NIBBLE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a multiplexed active-low 7-segment bus, debounces each (digit, pattern)
// pair and recovers a per-digit hex bank plus one handshaked event per new capture.
module seven_segment_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SEG_W-1:0]               seg_in,
    input  logic [NUM_DIGITS-1:0]          dig_sel_in,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [$clog2(NUM_DIGITS)-1:0]  evt_digit,
    output logic [NIBBLE_W-1:0]            evt_nibble,
    output logic                           evt_blank,
    output logic [NIBBLE_W*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]          blank_out,
    output logic                           illegal_err,
    output logic                           overflow_err,
    input  logic                           err_clr
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SEG_W-1:0]      seg_meta, seg_s, seg_prev;
    logic [NUM_DIGITS-1:0] sel_meta, sel_s, sel_prev;
    logic [CNT_W-1:0]      count, count_next;
    logic                  captured, captured_next;
    logic                  changed_c, fire_c;
    logic                  sel_none_c, sel_onecold_c;
    logic [IDX_W-1:0]      sel_idx_c;
    logic                  cap_c, illegal_set_c, overflow_set_c;
    logic                  transfer_c;
    seg7_decode_t          dec_c;

    seg7_pattern_to_hex u_decode (
        .pattern (seg_s),
        .result  (dec_c)
    );

    // Stability tracking: capture fires once, in the cycle the count reaches its limit.
    always_comb begin
        changed_c = {sel_s, seg_s} != {sel_prev, seg_prev};
        if (changed_c) begin
            count_next = CNT_W'(1);
        end else if (count == CNT_MAX) begin
            count_next = count;
        end else begin
            count_next = count + CNT_W'(1);
        end
        fire_c        = !changed_c && (count_next == CNT_MAX) && !captured;
        captured_next = changed_c ? 1'b0 : (captured | fire_c);
    end

    // Digit select classification; index is the position of the single low bit.
    always_comb begin
        sel_none_c    = &sel_s;
        sel_onecold_c = $onehot(~sel_s);
        sel_idx_c     = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!sel_s[i]) begin
                sel_idx_c = IDX_W'(i);
            end
        end
    end

    // Capture outcome: bank/event update, or an illegal flag when select or glyph is bad.
    always_comb begin
        transfer_c     = evt_valid && evt_ready;
        cap_c          = fire_c && sel_onecold_c && dec_c.legal;
        illegal_set_c  = fire_c && !sel_none_c && (!sel_onecold_c || !dec_c.legal);
        overflow_set_c = cap_c && evt_valid && !evt_ready;
    end

    // Two-flop synchronizers, previous-sample register and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta <= '1;
            seg_s    <= '1;
            sel_meta <= '1;
            sel_s    <= '1;
            seg_prev <= '1;
            sel_prev <= '1;
            count    <= '0;
            captured <= 1'b0;
        end else begin
            seg_meta <= seg_in;
            seg_s    <= seg_meta;
            sel_meta <= dig_sel_in;
            sel_s    <= sel_meta;
            seg_prev <= seg_s;
            sel_prev <= sel_s;
            count    <= count_next;
            captured <= captured_next;
        end
    end

    // Single-entry event register; a capture during a transfer reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid  <= 1'b0;
            evt_digit  <= '0;
            evt_nibble <= '0;
            evt_blank  <= 1'b0;
        end else if (cap_c && (!evt_valid || evt_ready)) begin
            evt_valid  <= 1'b1;
            evt_digit  <= sel_idx_c;
            evt_nibble <= dec_c.blank ? '0 : dec_c.nibble;
            evt_blank  <= dec_c.blank;
        end else if (transfer_c) begin
            evt_valid  <= 1'b0;
        end
    end

    // Per-digit bank; a blank capture keeps the old value and only raises the blank flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_out <= '0;
            blank_out  <= '1;
        end else if (cap_c) begin
            if (dec_c.blank) begin
                blank_out[sel_idx_c] <= 1'b1;
            end else begin
                blank_out[sel_idx_c] <= 1'b0;
                digits_out[32'(sel_idx_c)*NIBBLE_W +: NIBBLE_W] <= dec_c.nibble;
            end
        end
    end

    // Sticky error flags; a set in the same cycle beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_err  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (illegal_set_c) begin
                illegal_err <= 1'b1;
            end else if (err_clr) begin
                illegal_err <= 1'b0;
            end
            if (overflow_set_c) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: latency, debounce, errors, handshake, scan, reset.
module tb_seven_segment_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_digit;
    logic [3:0]  evt_nibble;
    logic        evt_blank;
    logic [15:0] digits_out;
    logic [3:0]  blank_out;
    logic        illegal_err;
    logic        overflow_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;
    logic [6:0] evq[$];

    always #5 clk = ~clk;

    seven_segment_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_in       (seg_in),
        .dig_sel_in   (dig_sel_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_digit    (evt_digit),
        .evt_nibble   (evt_nibble),
        .evt_blank    (evt_blank),
        .digits_out   (digits_out),
        .blank_out    (blank_out),
        .illegal_err  (illegal_err),
        .overflow_err (overflow_err),
        .err_clr      (err_clr)
    );

    // Log every transferred event as {blank, digit, nibble}.
    always @(posedge clk) begin
        if (rst_n && evt_valid && evt_ready) evq.push_back({evt_blank, evt_digit, evt_nibble});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        dig_sel_in = 4'b1111;
        seg_in     = 7'b1111111;
        tick(8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seg_in = 7'b1111111; dig_sel_in = 4'b1111;
        evt_ready = 1'b1; err_clr = 1'b0;
        tick(2);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
        checks++; if (digits_out !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", digits_out); end
        checks++; if (blank_out !== 4'b1111) begin errors++; $display("FAIL reset_blank got %b want 1111", blank_out); end
        checks++; if ({illegal_err, overflow_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b want 00", {illegal_err, overflow_err}); end
        checks++; if ({evt_digit, evt_nibble, evt_blank} !== 7'd0) begin errors++; $display("FAIL reset_evt got %h want 0", {evt_digit, evt_nibble, evt_blank}); end
        rst_n = 1'b1;
        tick(8);
    endtask

    task automatic test_basic();
        evq.delete();
        dig_sel_in = 4'b1110; seg_in = 7'b0100100;
        tick(5);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL basic_edge5_valid got %b want 0", evt_valid); end
        tick(1);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL basic_edge6_valid got %b want 1", evt_valid); end
        checks++; if ({evt_blank, evt_digit, evt_nibble} !== {1'b0, 2'd0, 4'd2}) begin errors++; $display("FAIL basic_evt got %h want 02", {evt_blank, evt_digit, evt_nibble}); end
        checks++; if (digits_out !== 16'h0002) begin errors++; $display("FAIL basic_digits got %h want 0002", digits_out); end
        checks++; if (blank_out !== 4'b1110) begin errors++; $display("FAIL basic_blank got %b want 1110", blank_out); end
        tick(4);
        checks++; if (evq.size() !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", evq.size()); end
        go_idle();
    endtask

    task automatic test_glitch();
        evq.delete();
        dig_sel_in = 4'b1110; seg_in = 7'b0010010;
        tick(3);
        seg_in = 7'b0000000;
        tick(1);
        seg_in = 7'b0010010;
        tick(5);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL glitch_early_valid got %b want 0", evt_valid); end
        tick(1);
        checks++; if (evt_valid !== 1'b1 || evt_nibble !== 4'd5) begin errors++; $display("FAIL glitch_capture got v=%b n=%h want v=1 n=5", evt_valid, evt_nibble); end
        tick(6);
        checks++; if (evq.size() !== 1) begin errors++; $display("FAIL glitch_count got %0d want 1", evq.size()); end
        else begin
            checks++; if (evq[0] !== {1'b0, 2'd0, 4'd5}) begin errors++; $display("FAIL glitch_evt got %h want 05", evq[0]); end
        end
        checks++; if (digits_out !== 16'h0005) begin errors++; $display("FAIL glitch_digits got %h want 0005", digits_out); end
        go_idle();
    endtask

    task automatic test_illegal();
        evq.delete();
        dig_sel_in = 4'b1101; seg_in = 7'b1010101;
        tick(10);
        checks++; if (illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_glyph_err got %b want 1", illegal_err); end
        checks++; if (evt_valid !== 1'b0 || evq.size() !== 0) begin errors++; $display("FAIL illegal_glyph_evt got v=%b n=%0d want v=0 n=0", evt_valid, evq.size()); end
        checks++; if (digits_out !== 16'h0005 || blank_out !== 4'b1110) begin errors++; $display("FAIL illegal_glyph_bank got %h/%b want 0005/1110", digits_out, blank_out); end
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        checks++; if (illegal_err !== 1'b0) begin errors++; $display("FAIL illegal_clr got %b want 0", illegal_err); end
        dig_sel_in = 4'b1100; seg_in = 7'b1111001;
        tick(10);
        checks++; if (illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_sel_err got %b want 1", illegal_err); end
        checks++; if (evq.size() !== 0 || digits_out !== 16'h0005) begin errors++; $display("FAIL illegal_sel_bank got n=%0d d=%h want n=0 d=0005", evq.size(), digits_out); end
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        checks++; if (illegal_err !== 1'b0) begin errors++; $display("FAIL illegal_sel_clr got %b want 0", illegal_err); end
        go_idle();
    endtask

    task automatic test_overflow();
        evq.delete();
        evt_ready = 1'b0;
        dig_sel_in = 4'b1101; seg_in = 7'b1111000;
        tick(8);
        checks++; if ({evt_valid, evt_digit, evt_nibble} !== {1'b1, 2'd1, 4'd7}) begin errors++; $display("FAIL ovf_first got %h want 17", {evt_valid, evt_digit, evt_nibble}); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow_err); end
        dig_sel_in = 4'b1011; seg_in = 7'b0110000;
        tick(8);
        checks++; if ({evt_valid, evt_digit, evt_nibble} !== {1'b1, 2'd1, 4'd7}) begin errors++; $display("FAIL ovf_held got %h want 17", {evt_valid, evt_digit, evt_nibble}); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow_err); end
        checks++; if (digits_out !== 16'h0375 || blank_out !== 4'b1000) begin errors++; $display("FAIL ovf_bank got %h/%b want 0375/1000", digits_out, blank_out); end
        evt_ready = 1'b1;
        tick(1);
        checks++; if (evt_valid !== 1'b0 || evq.size() !== 1) begin errors++; $display("FAIL ovf_drain got v=%b n=%0d want v=0 n=1", evt_valid, evq.size()); end
        else begin
            checks++; if (evq[0] !== {1'b0, 2'd1, 4'd7}) begin errors++; $display("FAIL ovf_drain_evt got %h want 17", evq[0]); end
        end
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow_err); end
        go_idle();
    endtask

    task automatic test_scan();
        logic [3:0] sels [4];
        logic [6:0] segs [4];
        logic [6:0] want [4];
        sels = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        segs = '{7'b1000000, 7'b0001000, 7'b0001110, 7'b1111111};
        want = '{{1'b0, 2'd0, 4'h0}, {1'b0, 2'd1, 4'hA}, {1'b0, 2'd2, 4'hF}, {1'b1, 2'd3, 4'h0}};
        evq.delete();
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dig_sel_in = sels[i]; seg_in = segs[i];
            tick(8);
        end
        checks++; if (evq.size() !== 4) begin errors++; $display("FAIL scan_count got %0d want 4", evq.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (evq[i] !== want[i]) begin errors++; $display("FAIL scan_evt%0d got %h want %h", i, evq[i], want[i]); end
            end
        end
        checks++; if (digits_out !== 16'h0FA0) begin errors++; $display("FAIL scan_digits got %h want 0fa0", digits_out); end
        checks++; if (blank_out !== 4'b1000) begin errors++; $display("FAIL scan_blank got %b want 1000", blank_out); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        dig_sel_in = 4'b0111; seg_in = 7'b0000000;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        checks++; if (evt_valid !== 1'b0 || digits_out !== 16'h0000) begin errors++; $display("FAIL rstmid_state got v=%b d=%h want v=0 d=0000", evt_valid, digits_out); end
        checks++; if (blank_out !== 4'b1111 || {illegal_err, overflow_err} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b/%b want 1111/00", blank_out, {illegal_err, overflow_err}); end
        rst_n = 1'b1;
        tick(5);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early got %b want 0", evt_valid); end
        tick(1);
        checks++; if ({evt_valid, evt_blank, evt_digit, evt_nibble} !== {1'b1, 1'b0, 2'd3, 4'd8}) begin errors++; $display("FAIL rstmid_evt got %h want 38", {evt_valid, evt_blank, evt_digit, evt_nibble}); end
        checks++; if (digits_out !== 16'h8000 || blank_out !== 4'b0111) begin errors++; $display("FAIL rstmid_bank got %h/%b want 8000/0111", digits_out, blank_out); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_illegal();
        test_overflow();
        test_scan();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
